sd_decimator: RTL

SD_DECIMATOR -- requirements
Module: sd_decimator

---
 rtl/sd_pkg.sv | 17 +
 rtl/sd_integrator.sv | 30 +++
 rtl/sd_decimator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and sizing helpers for the sigma-delta CIC decimator.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } sd_state_t;

  localparam int DEC_RATIO_DEFAULT = 64;

  // Exact width of a 2nd-order CIC with a 1-bit input: result never exceeds ratio^2.
  function automatic int cic_width(input int ratio);
    return 2 * $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/sd_integrator.sv
// Enable-gated wrap-around accumulator; o_sum is the value the register takes on
// an enabled edge, so downstream stages can see the post-update value.
module sd_integrator
  import sd_pkg::*;
#(
  parameter int CW = cic_width(DEC_RATIO_DEFAULT)
) (
  input  logic          clck,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_din,
  output logic [CW-1:0] o_sum
);

  logic [CW-1:0] r_acc;

  assign o_sum = r_acc + i_din;

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/sd_decimator.sv
// 2nd-order CIC decimator for a 1-bit sigma-delta stream with a valid/ready
// output register and a sticky overrun flag.
module sd_decimator
  import sd_pkg::*;
#(
  parameter int DEC_RATIO = DEC_RATIO_DEFAULT,
  parameter int OUT_W     = 16
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = cic_width(DEC_RATIO);
  localparam int PW = $clog2(DEC_RATIO);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DEC_RATIO - 1);

  sd_state_t r_state, w_state_next;

  logic [PW-1:0]    r_phase;
  logic             r_fill_cnt;
  logic [CW-1:0]    r_d1, r_d2;
  logic [OUT_W-1:0] r_sample;
  logic             r_valid, r_overrun;

  logic          w_clear, w_accept, w_dec, w_emit;
  logic [CW-1:0] w_bit, w_i1_sum, w_i2_sum, w_c1, w_c2;

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_next = ST_FILL;
      ST_FILL: begin
        if (!en) begin
          w_state_next = ST_IDLE;
        end else if (w_dec && r_fill_cnt) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN:  if (!en) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clear  = 1'b0;
    w_accept = 1'b0;
    w_dec    = 1'b0;
    w_emit   = 1'b0;
    w_clear  = (r_state == ST_IDLE) || !en;
    w_accept = en && bit_valid && (r_state != ST_IDLE);
    w_dec    = w_accept && (r_phase == LAST_PHASE);
    w_emit   = w_dec && (r_state == ST_RUN);
  end

  assign w_bit = {{(CW-1){1'b0}}, bit_in};

  sd_integrator #(.CW(CW)) u_int1 (
    .clck  (clck),
    .rst   (rst),
    .i_clr (w_clear),
    .i_en  (w_accept),
    .i_din (w_bit),
    .o_sum (w_i1_sum)
  );

  sd_integrator #(.CW(CW)) u_int2 (
    .clck  (clck),
    .rst   (rst),
    .i_clr (w_clear),
    .i_en  (w_accept),
    .i_din (w_i1_sum),
    .o_sum (w_i2_sum)
  );

  // Two combs, differential delay 1 at the decimated rate.
  assign w_c1 = w_i2_sum - r_d1;
  assign w_c2 = w_c1 - r_d2;

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_fill_cnt <= 1'b0;
      r_d1       <= '0;
      r_d2       <= '0;
    end else if (w_clear) begin
      r_phase    <= '0;
      r_fill_cnt <= 1'b0;
      r_d1       <= '0;
      r_d2       <= '0;
    end else begin
      if (w_accept) r_phase <= r_phase + PW'(1);
      if (w_dec) begin
        r_d1 <= w_i2_sum;
        r_d2 <= w_c1;
        if (r_state == ST_FILL) r_fill_cnt <= 1'b1;
      end
    end
  end

  // Output register survives en=0 so an unconsumed sample is never lost.
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || sample_ready)) begin
        r_sample <= OUT_W'(w_c2);
        r_valid  <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_valid && !sample_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
